// File: rtl/mac_cfg_pkg.sv
// mac_cfg_pkg: register map, reset values, field positions and state encoding for the MAC config responder
package mac_cfg_pkg;
  localparam int A_REV = 'h00, A_SCRATCH = 'h01, A_CMD = 'h02, A_MAC0 = 'h03, A_MAC1 = 'h04;
  localparam int A_FRM_LEN = 'h05, A_PAUSE = 'h06, A_FIFO_LO = 'h07, A_FIFO_HI = 'h0e;
  localparam int A_IPG = 'h17, A_TX_STAT = 'h3a, A_RX_STAT = 'h3b;
  localparam logic [15:0] FRM_LEN_RST = 16'd1518;
  localparam logic [4:0] IPG_RST = 5'd12;
  localparam int CMD_TX_ENA = 0, CMD_RX_ENA = 1, CMD_SW_RESET = 13;
  localparam int IPG_MIN = 8, IPG_MAX = 26;
  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, SW_RST} state_t;
  typedef struct packed {
    logic [31:0] scratch;
    logic [31:0] cmd;
    logic [31:0] mac_0;
    logic [15:0] mac_1;
    logic [15:0] frm_len;
    logic [15:0] pause;
    logic [7:0][31:0] fifo;
    logic [4:0] ipg;
    logic [31:0] tx_stat;
    logic [31:0] rx_stat;
  } regs_t;
  localparam regs_t REGS_RST = '{frm_len: FRM_LEN_RST, ipg: IPG_RST, default: '0};
  function automatic logic [4:0] sat_ipg(input logic [31:0] v);
    return v < 32'(IPG_MIN) ? 5'(IPG_MIN) : v > 32'(IPG_MAX) ? 5'(IPG_MAX) : v[4:0];
  endfunction
endpackage

// File: rtl/mac_cfg_rdmux.sv
// mac_cfg_rdmux: address-to-read-data mux; unmapped addresses read as zero
module mac_cfg_rdmux
  import mac_cfg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter logic [31:0] REV = 32'h0000_0901
) (
  input  logic [ADDR_W-1:0] addr,
  input  regs_t             regs,
  output logic [DATA_W-1:0] rdata
);
  int a;
  logic [31:0] v;
  always_comb begin
    a = int'(addr);
    v = '0;
    case (a)
      A_REV:     v = REV;
      A_SCRATCH: v = regs.scratch;
      A_CMD:     v = regs.cmd;
      A_MAC0:    v = regs.mac_0;
      A_MAC1:    v = 32'(regs.mac_1);
      A_FRM_LEN: v = 32'(regs.frm_len);
      A_PAUSE:   v = 32'(regs.pause);
      A_IPG:     v = 32'(regs.ipg);
      A_TX_STAT: v = regs.tx_stat;
      A_RX_STAT: v = regs.rx_stat;
      default:   v = (a >= A_FIFO_LO && a <= A_FIFO_HI) ? regs.fifo[3'(a - A_FIFO_LO)] : '0;
    endcase
  end
  assign rdata = DATA_W'(v);
endmodule

// File: rtl/mac_cfg_regfile.sv
// mac_cfg_regfile: MAC config bus responder with busy/read latency timing and self-clearing software reset
module mac_cfg_regfile
  import mac_cfg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int WR_LAT = 2,
  parameter int RD_LAT = 3,
  parameter int RST_CYC = 16,
  parameter logic [31:0] REV = 32'h0000_0901
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_vld,
  output logic [47:0]       mac_local,
  output logic              tx_ena,
  output logic              rx_ena,
  output logic [15:0]       frm_max_len,
  output logic [4:0]        tx_ipg,
  output logic              prot_err
);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q;
  regs_t regs;
  logic [31:0] wd;
  logic [DATA_W-1:0] rd_val;
  logic idle, wr_acc, rd_acc, sw_go, rd_fire, rst_done;
  int wa;
  assign idle = state_q == IDLE;
  assign wr_acc = idle && wr_en;
  assign rd_acc = idle && rd_en && !wr_en;
  assign wa = int'(addr);
  assign wd = 32'(wdata);
  assign sw_go = wr_acc && wa == A_CMD && wd[CMD_SW_RESET];
  // read data is captured one cycle before the valid pulse so it appears with it
  assign rd_fire = (rd_acc && RD_LAT == 1) || (state_q == RD_BUSY && cnt_q == 16'd1);
  assign rst_done = state_q == SW_RST && cnt_q == '0;
  assign rdy = idle && !wr_en && !rd_en;
  mac_cfg_rdmux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REV(REV)) u_rdmux (
    .addr(idle ? addr : rd_addr_q),
    .regs(regs),
    .rdata(rd_val)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (sw_go) begin
      state_d = SW_RST;
      cnt_d = 16'(RST_CYC - 1);
    end else if (wr_acc && WR_LAT > 0) begin
      state_d = WR_BUSY;
      cnt_d = 16'(WR_LAT - 1);
    end else if (rd_acc) begin
      state_d = RD_BUSY;
      cnt_d = 16'(RD_LAT - 1);
    end else if (!idle) begin
      state_d = cnt_q == '0 ? IDLE : state_q;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 16'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs <= REGS_RST;
      rd_addr_q <= '0;
      rdata <= '0;
      rdata_vld <= 1'b0;
      prot_err <= 1'b0;
    end else begin
      rdata_vld <= rd_fire;
      if (rd_fire) rdata <= rd_val;
      if (rd_acc) rd_addr_q <= addr;
      if ((!idle && (wr_en || rd_en)) || (wr_en && rd_en)) prot_err <= 1'b1;
      if (rst_done) regs.cmd[CMD_SW_RESET] <= 1'b0;
      if (wr_acc)
        case (wa)
          A_SCRATCH: regs.scratch <= wd;
          A_CMD:     regs.cmd <= wd;
          A_MAC0:    regs.mac_0 <= wd;
          A_MAC1:    regs.mac_1 <= wd[15:0];
          A_FRM_LEN: regs.frm_len <= wd[15:0];
          A_PAUSE:   regs.pause <= wd[15:0];
          A_IPG:     regs.ipg <= sat_ipg(wd);
          A_TX_STAT: regs.tx_stat <= wd;
          A_RX_STAT: regs.rx_stat <= wd;
          default:   if (wa >= A_FIFO_LO && wa <= A_FIFO_HI) regs.fifo[3'(wa - A_FIFO_LO)] <= wd;
        endcase
    end
  assign mac_local = {regs.mac_0[7:0], regs.mac_0[15:8], regs.mac_0[23:16], regs.mac_0[31:24],
                      regs.mac_1[7:0], regs.mac_1[15:8]};
  assign tx_ena = regs.cmd[CMD_TX_ENA] && state_q != SW_RST;
  assign rx_ena = regs.cmd[CMD_RX_ENA] && state_q != SW_RST;
  assign frm_max_len = regs.frm_len;
  assign tx_ipg = regs.ipg;
endmodule
